nmea_lat_extractor: RTL and testbench
=====================================

Name: nmea_lat_extractor

Overview:
Downstream consumer of the UART receive FIFO. It pops received bytes, parses NMEA-0183 GGA sentences, and verifies the checksum. On each valid sentence it publishes a 16-character, space-padded latitude line (e.g. "LAT:4807.038 N  ") for the LCD1602 controller. The output line stays stable between commits, so the LCD always shows the last good fix.

Parameters:
DATA_BITS, 8, character width; must be 8.
LINE_CHARS, 16, characters per output line (one LCD row).
MAX_LAT_CHARS, 10, longest latitude field accepted.
CHECKSUM_EN, 1, 1 = verify "*hh" before commit; 0 = commit on '*'.

Ports:
clk_50MHz  input  1  system clock
reset  input  1  asynchronous, active-low reset
fifo_empty  input  1  FIFO empty flag
fifo_data_in  input  8  FIFO head byte (show-ahead, valid while fifo_empty=0)
read_from_fifo  output  1  pop strobe to FIFO
lat_line  output  LINE_CHARS*8  committed line; char 0 in bits [7:0]
lat_valid  output  1  one-cycle pulse on commit
frame_error  output  1  one-cycle pulse on rejected GGA sentence
err_cause  output  2  0 lat overflow, 1 bad hemisphere, 2 checksum mismatch, 3 truncated; held until next error

Behaviour:
- Clock and reset: one clock, clk_50MHz. reset is asynchronous and active-low.
- Reset values: state S_IDLE; lat_line = all 0x20; lat_valid = 0; frame_error = 0; err_cause = 0; read_from_fifo = 0; shadow buffer = spaces; counters = 0.
- Pop rule: read_from_fifo = ~fifo_empty, combinational. The byte on fifo_data_in is consumed at the same clock edge. Throughput is one byte per cycle and there are no stall states.
- XOR accumulator: cleared on '$'. XORs every byte after '$' up to but not including '*'.
- '$' in any state: restart, clear the shadow buffer and index, go to S_HDR. This is not an error.
- S_IDLE: wait for '$'.
- S_HDR: compare against "GPGGA," using a 3-bit index. A mismatch returns to S_IDLE silently. After ',' go to S_SKIP_TIME.
- S_SKIP_TIME: discard bytes until ','. Shadow positions 0-3 are preloaded with "LAT:". Go to S_LAT.
- S_LAT: store bytes at shadow position 4+idx.
  - ',' goes to S_NS.
  - An empty field ("," immediately) goes to S_IDLE silently (no fix).
  - An 11th character is an error with cause 0.
- S_NS: accept 'N' or 'S' and store " N" or " S" right after the last latitude character. Next byte must be ','; go to S_TO_STAR. Any other byte is an error with cause 1.
- S_TO_STAR: consume until '*'. CR or LF before '*' is an error with cause 3.
  - CHECKSUM_EN=1: '*' goes to S_CK_HI.
  - CHECKSUM_EN=0: commit and go to S_IDLE.
- S_CK_HI / S_CK_LO: accept uppercase hex digits 0-9 and A-F only. A non-hex byte is an error with cause 3.
  - After S_CK_LO, compare the received value with the XOR accumulator.
  - Equal: commit. Different: error with cause 2. Either way go to S_IDLE.
- Commit: lat_line <= shadow at the edge after the final byte pops (1-cycle latency). lat_valid pulses high for that one cycle.
- Error: frame_error pulses one cycle and err_cause updates. Go to S_IDLE. lat_line is untouched.
- Trailing bytes: CR, LF and anything else after the checksum are discarded in S_IDLE.
- Bytes popped while in S_IDLE: dropped.
- Reset mid-sentence: the partial shadow is discarded and lat_line returns to spaces.

Decomposition:
- Shared package nmea_pkg:
  - state encoding
  - ASCII constants ('$', ',', '*', CR, LF, 'N', 'S', space)
  - GGA header string
  - err_cause codes
- One sub-module, nmea_hex_nibble: combinational ASCII-hex to 4-bit value plus an is_hex flag. It is used by both checksum states.

Test Plan:
- Valid sentence: "$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*47\r\n" fed back-to-back from the FIFO -> lat_valid pulses once, 1 cycle after '7' pops; lat_line = "LAT:4807.038 N  ".
- Same sentence with checksum "*48" -> frame_error pulse, err_cause=2; lat_line keeps its previous value (spaces after reset).
- "$GPRMC,..." followed by a valid GGA with latitude "3345.1234", hemisphere S -> RMC is ignored with no pulses; lat_line = "LAT:3345.1234 S ".
- Latitude field "12345.678901" (12 chars) -> frame_error with err_cause=0. A '$' arriving mid-sentence restarts parsing, and the following valid GGA commits normally.
- fifo_empty toggling every other cycle during a valid sentence -> read_from_fifo only asserts when non-empty; the result is identical to the back-to-back case.
- Reset asserted while in S_LAT -> all outputs return to reset values immediately. After release, a valid sentence commits correctly.

Source files
------------

// File: rtl/nmea_pkg.sv
// Shared types and ASCII constants for the NMEA GGA latitude extractor.
// The state encoding, header string and error codes live here so the RTL and the bench agree.
package nmea_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HDR       = 3'd1,
    S_SKIP_TIME = 3'd2,
    S_LAT       = 3'd3,
    S_NS        = 3'd4,
    S_TO_STAR   = 3'd5,
    S_CK_HI     = 3'd6,
    S_CK_LO     = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    ERR_LAT_OVF = 2'd0,
    ERR_HEMI    = 2'd1,
    ERR_CKSUM   = 2'd2,
    ERR_TRUNC   = 2'd3
  } err_t;

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_N      = 8'h4E;
  localparam logic [7:0] CH_S      = 8'h53;
  localparam logic [7:0] CH_SPACE  = 8'h20;

  localparam logic [47:0] GGA_HDR = "GPGGA,";

  // "LAT:" laid out LSB-first, so 'L' lands in line character 0.
  localparam logic [31:0] LAT_PREFIX = 32'h3A54_414C;

  function automatic logic [7:0] hdr_char(input logic [2:0] i);
    logic [2:0] pos;
    pos = 3'd5 - i;
    return GGA_HDR[{pos, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/nmea_lat_extractor_if.sv
// Bundles the FIFO pop interface and the committed latitude line outputs.
// master = the extractor, slave = the FIFO / LCD side.
interface nmea_lat_extractor_if #(
  parameter int LINE_CHARS = 16
);
  import nmea_pkg::*;

  logic                    fifo_empty;
  logic [7:0]              fifo_data_in;
  logic                    read_from_fifo;
  logic [LINE_CHARS*8-1:0] lat_line;
  logic                    lat_valid;
  logic                    frame_error;
  logic [1:0]              err_cause;
  state_t                  dbg_state;

  // A byte transfers on every clock edge where read_from_fifo is high;
  // read_from_fifo follows ~fifo_empty, so the extractor never back-pressures.
  modport master (
    input  fifo_empty, fifo_data_in,
    output read_from_fifo, lat_line, lat_valid, frame_error, err_cause, dbg_state
  );

  modport slave (
    output fifo_empty, fifo_data_in,
    input  read_from_fifo, lat_line, lat_valid, frame_error, err_cause, dbg_state
  );

endinterface

// File: rtl/nmea_hex_nibble.sv
// Combinational ASCII hex digit decoder; only uppercase A-F are accepted.
module nmea_hex_nibble (
  input  logic [7:0] ch,
  output logic [3:0] value,
  output logic       is_hex
);

  always_comb begin
    value  = 4'd0;
    is_hex = 1'b0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      is_hex = 1'b1;
      value  = ch[3:0];
    end else if (ch >= 8'h41 && ch <= 8'h46) begin
      // 'A'..'F' have low nibble 1..6
      is_hex = 1'b1;
      value  = ch[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/nmea_lat_extractor.sv
// Parses GGA sentences from the UART FIFO, checks "*hh" and publishes a
// 16-char latitude line that only changes on a good sentence.
module nmea_lat_extractor
  import nmea_pkg::*;
#(
  parameter int DATA_BITS     = 8,
  parameter int LINE_CHARS    = 16,
  parameter int MAX_LAT_CHARS = 10,
  parameter int CHECKSUM_EN   = 1
) (
  input logic                  clk_50MHz,
  input logic                  reset,
  nmea_lat_extractor_if.master bus
);

  localparam int POS_W = $clog2(LINE_CHARS * 8);
  localparam logic [LINE_CHARS*8-1:0] SPACES = {LINE_CHARS{CH_SPACE}};

  state_t                  state, state_next;
  logic [DATA_BITS-1:0]    rx_byte;
  logic                    pop;
  logic [LINE_CHARS*8-1:0] shadow;
  logic [3:0]              idx;
  logic [7:0]              xacc;
  logic [3:0]              ck_hi;
  logic                    hemi_seen;
  logic [3:0]              nib;
  logic                    nib_ok;
  logic [POS_W-1:0]        lat_bit, hemi_bit;

  logic restart, xor_en, idx_inc, idx_clr, load_prefix, store_lat, store_hemi;
  logic ck_load, commit, err;
  err_t err_code;

  assign rx_byte            = bus.fifo_data_in;
  assign pop                = ~bus.fifo_empty;
  assign bus.read_from_fifo = pop;
  assign bus.dbg_state      = state;

  assign lat_bit  = POS_W'({idx + 4'd4, 3'b000});
  assign hemi_bit = lat_bit + POS_W'(8);

  nmea_hex_nibble u_hex (
    .ch     (rx_byte),
    .value  (nib),
    .is_hex (nib_ok)
  );

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    restart     = 1'b0;
    xor_en      = 1'b0;
    idx_inc     = 1'b0;
    idx_clr     = 1'b0;
    load_prefix = 1'b0;
    store_lat   = 1'b0;
    store_hemi  = 1'b0;
    ck_load     = 1'b0;
    commit      = 1'b0;
    err         = 1'b0;
    err_code    = ERR_LAT_OVF;
    if (pop) begin
      if (rx_byte == CH_DOLLAR) begin
        restart    = 1'b1;
        state_next = S_HDR;
      end else begin
        unique case (state)
          S_IDLE: ;
          S_HDR: begin
            xor_en = 1'b1;
            if (rx_byte != hdr_char(idx[2:0])) begin
              state_next = S_IDLE;
            end else if (idx == 4'd5) begin
              idx_clr    = 1'b1;
              state_next = S_SKIP_TIME;
            end else begin
              idx_inc = 1'b1;
            end
          end
          S_SKIP_TIME: begin
            xor_en = 1'b1;
            if (rx_byte == CH_COMMA) begin
              load_prefix = 1'b1;
              state_next  = S_LAT;
            end
          end
          S_LAT: begin
            xor_en = 1'b1;
            if (rx_byte == CH_COMMA) begin
              // An empty latitude field means no fix: drop silently.
              state_next = (idx == 4'd0) ? S_IDLE : S_NS;
            end else if (idx == 4'(MAX_LAT_CHARS)) begin
              err        = 1'b1;
              err_code   = ERR_LAT_OVF;
              state_next = S_IDLE;
            end else begin
              store_lat = 1'b1;
              idx_inc   = 1'b1;
            end
          end
          S_NS: begin
            xor_en = 1'b1;
            if (!hemi_seen && (rx_byte == CH_N || rx_byte == CH_S)) begin
              store_hemi = 1'b1;
            end else if (hemi_seen && rx_byte == CH_COMMA) begin
              state_next = S_TO_STAR;
            end else begin
              err        = 1'b1;
              err_code   = ERR_HEMI;
              state_next = S_IDLE;
            end
          end
          S_TO_STAR: begin
            if (rx_byte == CH_STAR) begin
              if (CHECKSUM_EN != 0) begin
                state_next = S_CK_HI;
              end else begin
                commit     = 1'b1;
                state_next = S_IDLE;
              end
            end else if (rx_byte == CH_CR || rx_byte == CH_LF) begin
              err        = 1'b1;
              err_code   = ERR_TRUNC;
              state_next = S_IDLE;
            end else begin
              xor_en = 1'b1;
            end
          end
          S_CK_HI: begin
            if (nib_ok) begin
              ck_load    = 1'b1;
              state_next = S_CK_LO;
            end else begin
              err        = 1'b1;
              err_code   = ERR_TRUNC;
              state_next = S_IDLE;
            end
          end
          S_CK_LO: begin
            state_next = S_IDLE;
            if (!nib_ok) begin
              err      = 1'b1;
              err_code = ERR_TRUNC;
            end else if ({ck_hi, nib} == xacc) begin
              commit = 1'b1;
            end else begin
              err      = 1'b1;
              err_code = ERR_CKSUM;
            end
          end
          default: state_next = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      shadow          <= SPACES;
      idx             <= 4'd0;
      xacc            <= 8'd0;
      ck_hi           <= 4'd0;
      hemi_seen       <= 1'b0;
      bus.lat_line    <= SPACES;
      bus.lat_valid   <= 1'b0;
      bus.frame_error <= 1'b0;
      bus.err_cause   <= 2'd0;
    end else begin
      bus.lat_valid   <= commit;
      bus.frame_error <= err;
      if (err)    bus.err_cause <= err_code;
      if (commit) bus.lat_line  <= shadow;
      if (restart) begin
        shadow    <= SPACES;
        idx       <= 4'd0;
        xacc      <= 8'd0;
        hemi_seen <= 1'b0;
      end else begin
        if (xor_en)      xacc <= xacc ^ rx_byte;
        if (idx_clr)     idx <= 4'd0;
        else if (idx_inc) idx <= idx + 4'd1;
        if (load_prefix) shadow[31:0] <= LAT_PREFIX;
        if (store_lat)   shadow[lat_bit +: 8] <= rx_byte;
        if (store_hemi) begin
          shadow[lat_bit +: 8]  <= CH_SPACE;
          shadow[hemi_bit +: 8] <= rx_byte;
          hemi_seen             <= 1'b1;
        end
        if (ck_load) ck_hi <= nib;
      end
    end
  end

endmodule

// File: tb/tb_nmea_lat_extractor.sv
// Directed bench for nmea_lat_extractor: feeds NMEA byte streams through the
// FIFO pins and compares the committed line and pulses with hand-written values.
module tb_nmea_lat_extractor;
  import nmea_pkg::*;

  localparam int LC = 16;
  localparam string REF_GGA = "$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*47";
  localparam string BAD_GGA = "$GPGGA,123519,4807.038,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*48";

  logic clk_50MHz = 1'b0;
  logic reset;

  always #10 clk_50MHz = ~clk_50MHz;

  nmea_lat_extractor_if #(.LINE_CHARS(LC)) bus ();

  nmea_lat_extractor #(
    .DATA_BITS     (8),
    .LINE_CHARS    (LC),
    .MAX_LAT_CHARS (10),
    .CHECKSUM_EN   (1)
  ) dut (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  int v0, e0;
  byte unsigned q[$];

  always @(negedge clk_50MHz) begin
    if (bus.lat_valid)   valid_cnt++;
    if (bus.frame_error) err_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [127:0] line_of(input string s);
    logic [127:0] l;
    l = {16{8'h20}};
    for (int i = 0; i < s.len() && i < 16; i++) l[i*8 +: 8] = s[i];
    return l;
  endfunction

  function automatic logic [7:0] hex_ch(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h37 + 8'(n);
  endfunction

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endtask

  // Builds a GGA sentence around lat/hemi with a correctly computed checksum (no CR/LF).
  task automatic push_gga(input string lat, input string hemi);
    string body;
    logic [7:0] ck;
    body = {"GPGGA,123519,", lat, ",", hemi, ",01131.000,E,1,08,0.9,545.4,M,46.9,M,,"};
    ck = 8'h00;
    for (int i = 0; i < body.len(); i++) ck = ck ^ body[i];
    push_str({"$", body, "*"});
    q.push_back(hex_ch(ck[7:4]));
    q.push_back(hex_ch(ck[3:0]));
  endtask

  // Returns 1 time unit after the edge that popped the last queued byte.
  task automatic send(input bit gaps);
    while (q.size() > 0) begin
      if (gaps) begin
        @(negedge clk_50MHz);
        bus.fifo_empty = 1'b1;
        #1 check("rd_when_empty", bus.read_from_fifo, 1'b0);
      end
      @(negedge clk_50MHz);
      bus.fifo_empty   = 1'b0;
      bus.fifo_data_in = q.pop_front();
      #1;
      if (gaps) check("rd_when_data", bus.read_from_fifo, 1'b1);
      @(posedge clk_50MHz);
      #1 bus.fifo_empty = 1'b1;
    end
  endtask

  task automatic mark();
    v0 = valid_cnt;
    e0 = err_cnt;
  endtask

  initial begin
    reset            = 1'b0;
    bus.fifo_empty   = 1'b1;
    bus.fifo_data_in = 8'h00;
    repeat (3) @(posedge clk_50MHz);
    #1;
    check("rst_line",  bus.lat_line, line_of(""));
    check("rst_valid", bus.lat_valid, 1'b0);
    check("rst_ferr",  bus.frame_error, 1'b0);
    check("rst_cause", bus.err_cause, 2'd0);
    check("rst_rd",    bus.read_from_fifo, 1'b0);
    check("rst_state", bus.dbg_state, S_IDLE);
    @(negedge clk_50MHz);
    reset = 1'b1;

    // Wrong checksum right after reset: error, line stays blank.
    mark();
    push_str(BAD_GGA);
    send(1'b0);
    check("ck_bad_ferr",  bus.frame_error, 1'b1);
    check("ck_bad_cause", bus.err_cause, ERR_CKSUM);
    check("ck_bad_valid", bus.lat_valid, 1'b0);
    check("ck_bad_line",  bus.lat_line, line_of(""));
    push_str("\r\n");
    send(1'b0);
    check("ck_bad_nerr",   err_cnt - e0, 1);
    check("ck_bad_nvalid", valid_cnt - v0, 0);

    // Reference sentence back-to-back: commit one cycle after '7'.
    mark();
    push_str(REF_GGA);
    send(1'b0);
    check("ref_valid", bus.lat_valid, 1'b1);
    check("ref_line",  bus.lat_line, line_of("LAT:4807.038 N  "));
    check("ref_ferr",  bus.frame_error, 1'b0);
    push_str("\r");
    send(1'b0);
    check("ref_pulse_end", bus.lat_valid, 1'b0);
    push_str("\n");
    send(1'b0);
    check("ref_nvalid", valid_cnt - v0, 1);
    check("ref_nerr",   err_cnt - e0, 0);

    // RMC is ignored; following GGA with a 9-char southern latitude commits.
    mark();
    push_str("$GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W*6A\r\n");
    send(1'b0);
    check("rmc_nvalid", valid_cnt - v0, 0);
    check("rmc_nerr",   err_cnt - e0, 0);
    check("rmc_line",   bus.lat_line, line_of("LAT:4807.038 N  "));
    push_gga("3345.1234", "S");
    send(1'b0);
    check("south_valid", bus.lat_valid, 1'b1);
    check("south_line",  bus.lat_line, line_of("LAT:3345.1234 S "));
    push_str("\r\n");
    send(1'b0);

    // 12-char latitude overflows at the 11th character.
    mark();
    push_gga("12345.678901", "N");
    push_str("\r\n");
    send(1'b0);
    check("ovf_nerr",   err_cnt - e0, 1);
    check("ovf_cause",  bus.err_cause, ERR_LAT_OVF);
    check("ovf_nvalid", valid_cnt - v0, 0);
    check("ovf_line",   bus.lat_line, line_of("LAT:3345.1234 S "));

    // '$' mid-sentence restarts; the following sentence commits.
    mark();
    push_str("$GPGGA,123519,48");
    push_gga("5120.5", "N");
    send(1'b0);
    check("restart_valid", bus.lat_valid, 1'b1);
    check("restart_line",  bus.lat_line, line_of("LAT:5120.5 N    "));
    push_str("\r\n");
    send(1'b0);
    check("restart_nerr", err_cnt - e0, 0);

    // Bad hemisphere letter.
    mark();
    push_gga("4807.038", "E");
    push_str("\r\n");
    send(1'b0);
    check("hemi_nerr",  err_cnt - e0, 1);
    check("hemi_cause", bus.err_cause, ERR_HEMI);
    check("hemi_line",  bus.lat_line, line_of("LAT:5120.5 N    "));

    // CR before '*' is a truncated sentence.
    mark();
    push_str("$GPGGA,123519,4807.038,N,011\r\n");
    send(1'b0);
    check("trunc_nerr",  err_cnt - e0, 1);
    check("trunc_cause", bus.err_cause, ERR_TRUNC);

    // Empty latitude field: silent drop, err_cause held.
    mark();
    push_str("$GPGGA,123519,,N,01131.000,E,1,08,0.9,545.4,M,46.9,M,,*00\r\n");
    send(1'b0);
    check("empty_nerr",   err_cnt - e0, 0);
    check("empty_nvalid", valid_cnt - v0, 0);
    check("empty_cause",  bus.err_cause, ERR_TRUNC);

    // FIFO empty every other cycle: same result as back-to-back.
    mark();
    push_str(REF_GGA);
    send(1'b1);
    check("gap_valid", bus.lat_valid, 1'b1);
    check("gap_line",  bus.lat_line, line_of("LAT:4807.038 N  "));
    push_str("\r\n");
    send(1'b1);
    check("gap_nvalid", valid_cnt - v0, 1);

    // Reset in the middle of the latitude field.
    push_str("$GPGGA,123519,48");
    send(1'b0);
    check("mid_state", bus.dbg_state, S_LAT);
    #3 reset = 1'b0;
    #1;
    check("mid_rst_line",  bus.lat_line, line_of(""));
    check("mid_rst_cause", bus.err_cause, 2'd0);
    check("mid_rst_valid", bus.lat_valid, 1'b0);
    check("mid_rst_state", bus.dbg_state, S_IDLE);
    @(negedge clk_50MHz);
    reset = 1'b1;
    push_str(REF_GGA);
    send(1'b0);
    check("post_rst_valid", bus.lat_valid, 1'b1);
    check("post_rst_line",  bus.lat_line, line_of("LAT:4807.038 N  "));
    push_str("\r\n");
    send(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
